// File: rtl/register_file.sv
// register_file: 32 x 32-bit integer register file for the decode stage.
// Two combinational read ports with write-through bypass, one synchronous
// write port, synchronous active-high reset, r0 hardwired to zero.
module register_file #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 32
) (
    output logic [DATA_W-1:0] reg_rd_data1,
    output logic [DATA_W-1:0] reg_rd_data2,
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_wr_en,
    input  logic [ADDR_W-1:0] reg_wr_add,
    input  logic [DATA_W-1:0] reg_wr_data,
    input  logic [ADDR_W-1:0] reg_rd_add1,
    input  logic [ADDR_W-1:0] reg_rd_add2
);

    logic [DATA_W-1:0] regs [DEPTH];

    // A write that actually lands this cycle: not in reset, enabled, not r0.
    logic wr_live;
    assign wr_live = !rst && reg_wr_en && (reg_wr_add != '0);

    // Storage: reset clears every entry and wins over a same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[ADDR_W'(i)] <= '0;
            end
        end else if (wr_live) begin
            regs[reg_wr_add] <= reg_wr_data;
        end
    end

    // Read port 1: zero for r0 or during reset, bypass on address match.
    always_comb begin
        reg_rd_data1 = '0;
        if (!rst && (reg_rd_add1 != '0)) begin
            if (wr_live && (reg_wr_add == reg_rd_add1)) begin
                reg_rd_data1 = reg_wr_data;
            end else begin
                reg_rd_data1 = regs[reg_rd_add1];
            end
        end
    end

    // Read port 2: same rules as port 1, evaluated independently.
    always_comb begin
        reg_rd_data2 = '0;
        if (!rst && (reg_rd_add2 != '0)) begin
            if (wr_live && (reg_wr_add == reg_rd_add2)) begin
                reg_rd_data2 = reg_wr_data;
            end else begin
                reg_rd_data2 = regs[reg_rd_add2];
            end
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and randomized checks of register_file against
// an array-based model of the architectural register state.
module tb_register_file;

    logic [31:0] reg_rd_data1;
    logic [31:0] reg_rd_data2;
    logic        clk;
    logic        rst;
    logic        reg_wr_en;
    logic [4:0]  reg_wr_add;
    logic [31:0] reg_wr_data;
    logic [4:0]  reg_rd_add1;
    logic [4:0]  reg_rd_add2;

    int n_cmp = 0;
    int n_err = 0;

    // Architectural register contents as seen after each clock edge.
    logic [31:0] model_regs [32];

    register_file #(
        .DATA_W(32),
        .ADDR_W(5),
        .DEPTH (32)
    ) dut (
        .reg_rd_data1(reg_rd_data1),
        .reg_rd_data2(reg_rd_data2),
        .clk         (clk),
        .rst         (rst),
        .reg_wr_en   (reg_wr_en),
        .reg_wr_add  (reg_wr_add),
        .reg_wr_data (reg_wr_data),
        .reg_rd_add1 (reg_rd_add1),
        .reg_rd_add2 (reg_rd_add2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a read port must show right now, from the current inputs and state.
    function automatic logic [31:0] exp_read(input logic [4:0] a);
        if (rst || a == 5'd0) return 32'h0;
        if (reg_wr_en && reg_wr_add == a) return reg_wr_data;
        return model_regs[a];
    endfunction

    task automatic set_in(input logic r, input logic we, input logic [4:0] wa,
                          input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        rst = r; reg_wr_en = we; reg_wr_add = wa; reg_wr_data = wd;
        reg_rd_add1 = a1; reg_rd_add2 = a2;
    endtask

    // Advance one rising edge and apply the same edge to the model.
    task automatic clk_edge();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) model_regs[i] = 32'h0;
        end else if (reg_wr_en && reg_wr_add != 5'd0) begin
            model_regs[reg_wr_add] = reg_wr_data;
        end
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic test_reset();
        set_in(1'b1, 1'b1, 5'd4, 32'h1234_5678, 5'd4, 5'd0);
        clk_edge();
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h0) begin
            n_err++; $display("FAIL reset_held p1 got=%h exp=%h", reg_rd_data1, 32'h0);
        end
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        for (int a = 0; a < 32; a++) begin
            reg_rd_add1 = 5'(a);
            reg_rd_add2 = 5'(31 - a);
            settle();
            n_cmp++;
            if (reg_rd_data1 !== 32'h0) begin
                n_err++; $display("FAIL reset_sweep p1 addr=%0d got=%h exp=%h", a, reg_rd_data1, 32'h0);
            end
            n_cmp++;
            if (reg_rd_data2 !== 32'h0) begin
                n_err++; $display("FAIL reset_sweep p2 addr=%0d got=%h exp=%h", 31 - a, reg_rd_data2, 32'h0);
            end
        end
    endtask

    task automatic test_write_readback();
        logic [31:0] e1, e2;
        for (int a = 1; a < 32; a++) begin
            set_in(1'b0, 1'b1, 5'(a), 32'hA5A5_0000 + 32'(a), 5'd0, 5'd0);
            clk_edge();
        end
        for (int a = 1; a < 32; a++) begin
            set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(32 - a));
            settle();
            e1 = 32'hA5A5_0000 + 32'(a);
            e2 = 32'hA5A5_0000 + 32'(32 - a);
            n_cmp++;
            if (reg_rd_data1 !== e1) begin
                n_err++; $display("FAIL readback p1 addr=%0d got=%h exp=%h", a, reg_rd_data1, e1);
            end
            n_cmp++;
            if (reg_rd_data2 !== e2) begin
                n_err++; $display("FAIL readback p2 addr=%0d got=%h exp=%h", 32 - a, reg_rd_data2, e2);
            end
            clk_edge();
        end
    endtask

    task automatic test_r0();
        set_in(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h0 || reg_rd_data2 !== 32'h0) begin
            n_err++; $display("FAIL r0_same_cycle got=%h/%h exp=0", reg_rd_data1, reg_rd_data2);
        end
        clk_edge();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h0 || reg_rd_data2 !== 32'h0) begin
            n_err++; $display("FAIL r0_next_cycle got=%h/%h exp=0", reg_rd_data1, reg_rd_data2);
        end
    endtask

    task automatic test_bypass();
        set_in(1'b0, 1'b1, 5'd5, 32'h1111_1111, 5'd0, 5'd0);
        clk_edge();
        set_in(1'b0, 1'b1, 5'd5, 32'h2222_2222, 5'd5, 5'd5);
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h2222_2222 || reg_rd_data2 !== 32'h2222_2222) begin
            n_err++; $display("FAIL bypass_before got=%h/%h exp=22222222", reg_rd_data1, reg_rd_data2);
        end
        clk_edge();
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h2222_2222 || reg_rd_data2 !== 32'h2222_2222) begin
            n_err++; $display("FAIL bypass_after got=%h/%h exp=22222222", reg_rd_data1, reg_rd_data2);
        end
        set_in(1'b0, 1'b1, 5'd5, 32'h1111_1111, 5'd0, 5'd0);
        clk_edge();
        set_in(1'b0, 1'b0, 5'd5, 32'h2222_2222, 5'd5, 5'd5);
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h1111_1111 || reg_rd_data2 !== 32'h1111_1111) begin
            n_err++; $display("FAIL bypass_disabled got=%h/%h exp=11111111", reg_rd_data1, reg_rd_data2);
        end
        // Bypass on port 1 only; port 2 reads an untouched register.
        set_in(1'b0, 1'b1, 5'd5, 32'h3333_3333, 5'd5, 5'd6);
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h3333_3333) begin
            n_err++; $display("FAIL bypass_split p1 got=%h exp=%h", reg_rd_data1, 32'h3333_3333);
        end
        n_cmp++;
        if (reg_rd_data2 !== 32'hA5A5_0006) begin
            n_err++; $display("FAIL bypass_split p2 got=%h exp=%h", reg_rd_data2, 32'hA5A5_0006);
        end
        clk_edge();
    endtask

    task automatic test_back_to_back();
        set_in(1'b0, 1'b1, 5'd12, 32'h0000_00AA, 5'd0, 5'd0);
        clk_edge();
        set_in(1'b0, 1'b1, 5'd12, 32'h0000_00BB, 5'd0, 5'd0);
        clk_edge();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd12, 5'd12);
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h0000_00BB || reg_rd_data2 !== 32'h0000_00BB) begin
            n_err++; $display("FAIL back_to_back got=%h/%h exp=000000bb", reg_rd_data1, reg_rd_data2);
        end
    endtask

    task automatic test_reset_priority();
        set_in(1'b0, 1'b1, 5'd3, 32'h1234_5678, 5'd0, 5'd0);
        clk_edge();
        set_in(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd0, 5'd0);
        clk_edge();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h1234_5678 || reg_rd_data2 !== 32'hDEAD_BEEF) begin
            n_err++; $display("FAIL rstprio_setup got=%h/%h exp=12345678/deadbeef", reg_rd_data1, reg_rd_data2);
        end
        set_in(1'b1, 1'b1, 5'd3, 32'hCAFE_BABE, 5'd3, 5'd7);
        clk_edge();
        set_in(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7);
        settle();
        n_cmp++;
        if (reg_rd_data1 !== 32'h0 || reg_rd_data2 !== 32'h0) begin
            n_err++; $display("FAIL rstprio_after got=%h/%h exp=0", reg_rd_data1, reg_rd_data2);
        end
    endtask

    task automatic test_wr_en_gating();
        set_in(1'b0, 1'b1, 5'd9, 32'h0BAD_F00D, 5'd0, 5'd0);
        clk_edge();
        for (int c = 0; c < 4; c++) begin
            set_in(1'b0, 1'b0, 5'd9, 32'h5555_AAAA, 5'd9, 5'd9);
            settle();
            n_cmp++;
            if (reg_rd_data1 !== 32'h0BAD_F00D || reg_rd_data2 !== 32'h0BAD_F00D) begin
                n_err++; $display("FAIL wr_en_gating cyc=%0d got=%h/%h exp=0badf00d", c, reg_rd_data1, reg_rd_data2);
            end
            clk_edge();
        end
    endtask

    task automatic test_random();
        logic [4:0]  wa;
        logic [31:0] e1, e2;
        for (int c = 0; c < 400; c++) begin
            wa = 5'($urandom_range(0, 31));
            set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7), wa, $urandom(),
                   ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)),
                   ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31)));
            settle();
            e1 = exp_read(reg_rd_add1);
            e2 = exp_read(reg_rd_add2);
            n_cmp++;
            if (reg_rd_data1 !== e1) begin
                n_err++; $display("FAIL random p1 cyc=%0d addr=%0d got=%h exp=%h", c, reg_rd_add1, reg_rd_data1, e1);
            end
            n_cmp++;
            if (reg_rd_data2 !== e2) begin
                n_err++; $display("FAIL random p2 cyc=%0d addr=%0d got=%h exp=%h", c, reg_rd_add2, reg_rd_data2, e2);
            end
            clk_edge();
        end
    endtask

    initial begin
        set_in(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge clk);
        #1;
        test_reset();
        test_write_readback();
        test_r0();
        test_bypass();
        test_back_to_back();
        test_reset_priority();
        test_wr_en_gating();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
